// File: rtl/imem_loader.sv
// Byte-serial instruction memory loader. It takes a framed byte stream (count, big-endian
// words, XOR checksum) and writes the words at stepped addresses while holding the CPU.
module imem_loader #(
  parameter int DEPTH     = 64,
  parameter int ADDR_STEP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  // state   | meaning
  // S_IDLE  | out of reset, waiting for start
  // S_COUNT | expecting the word-count byte
  // S_HI    | expecting the high byte of a word
  // S_LO    | expecting the low byte; the write issues on the next cycle
  // S_CHECK | expecting the checksum byte
  // S_DONE  | load finished, checksum matched
  // S_ERROR | bad count or checksum mismatch
  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [8:0]  MAX_WORDS = 9'(DEPTH / ADDR_STEP);
  localparam logic [15:0] STEP      = 16'(ADDR_STEP);

  state_t      state;
  state_t      state_nxt;
  logic        busy_nxt;
  logic        xfer;
  logic        count_bad;
  logic [7:0]  remaining;
  logic [7:0]  hi_byte;
  logic [7:0]  checksum;
  logic [15:0] addr;

  assign xfer      = in_valid & in_ready;
  assign count_bad = (in_data == 8'd0) || ({1'b0, in_data} > MAX_WORDS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_nxt  = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_COUNT;
      S_COUNT: if (xfer) state_nxt = count_bad ? S_ERROR : S_HI;
      S_HI:    if (xfer) state_nxt = S_LO;
      // remaining is never zero here, so a value of one means this is the last word
      S_LO:    if (xfer) state_nxt = (remaining == 8'd1) ? S_CHECK : S_HI;
      S_CHECK: if (xfer) state_nxt = (in_data == checksum) ? S_DONE : S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt == S_COUNT) || (state_nxt == S_HI) ||
               (state_nxt == S_LO) || (state_nxt == S_CHECK);
  end

  // Status outputs are registered from the next state so they change together with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'd0;
      mem_wdata <= 16'd0;
      remaining <= 8'd0;
      hi_byte   <= 8'd0;
      checksum  <= 8'd0;
      addr      <= 16'd0;
    end else begin
      in_ready <= busy_nxt;
      cpu_hold <= busy_nxt;
      done     <= (state_nxt == S_DONE);
      error    <= (state_nxt == S_ERROR);
      mem_we   <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            checksum <= 8'd0;
            addr     <= 16'd0;
          end
        end
        S_COUNT: begin
          if (xfer) remaining <= in_data;
        end
        S_HI: begin
          if (xfer) begin
            hi_byte  <= in_data;
            checksum <= checksum ^ in_data;
          end
        end
        S_LO: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= {hi_byte, in_data};
            addr      <= addr + STEP;
            remaining <= remaining - 8'd1;
            checksum  <= checksum ^ in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: randomized framed streams with backpressure, checked against a
// stream-level model of the expected writes and final status.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_loader #(.DEPTH(64), .ADDR_STEP(2)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails = 0;
  int          stray = 0;
  bit          lo_flag = 1'b0;
  logic [7:0]  tx[$];
  logic [31:0] got[$];
  logic [31:0] exp_w[$];
  logic        exp_done;
  logic        exp_err;

  // Captured writes; a write is legal only in the cycle after an LO byte transfer.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got.push_back({mem_addr, mem_wdata});
      if (!lo_flag) stray++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_range(input int first, input int last, input int max_gap);
    int   budget;
    logic rdy;
    for (int k = first; k <= last; k++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
        lo_flag = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = tx[k];
      budget   = 0;
      do begin
        rdy = in_ready;
        tick();
        lo_flag = rdy && (k >= 2) && (k % 2 == 0) && (k < tx.size() - 1);
        budget++;
      end while (!rdy && budget < 64);
      if (!rdy) begin
        checks++;
        fails++;
        $display("FAIL handshake_timeout byte %0d: in_ready stayed 0, required 1", k);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic make_stream(input int n, input bit good_cs, input bit ones);
    logic [7:0] cs;
    logic [7:0] b;
    tx.delete();
    tx.push_back(8'(n));
    if (n < 1 || n > 32) return;
    cs = 8'd0;
    for (int i = 0; i < 2 * n; i++) begin
      b = ones ? 8'hFF : 8'($urandom);
      tx.push_back(b);
      cs ^= b;
    end
    tx.push_back(good_cs ? cs : cs ^ 8'($urandom_range(255, 1)));
  endtask

  // Reference: word i of a valid frame lands at byte address 2*i; status follows the checksum.
  task automatic build_expect();
    int         n;
    logic [7:0] cs;
    exp_w.delete();
    n = int'(tx[0]);
    if (n == 0 || n > 32) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
    end else begin
      cs = 8'd0;
      for (int i = 0; i < n; i++) begin
        exp_w.push_back({16'(2 * i), tx[1 + 2 * i], tx[2 + 2 * i]});
        cs = cs ^ tx[1 + 2 * i] ^ tx[2 + 2 * i];
      end
      exp_done = (tx[2 * n + 1] == cs);
      exp_err  = !exp_done;
    end
  endtask

  task automatic basic_stream();
    tx = '{8'h03, 8'h31, 8'h11, 8'h32, 8'h22, 8'h02, 8'h10, 8'h22};
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error} !== 37'd0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b, required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
    end
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({in_ready, cpu_hold, done, error} !== 4'b0000) begin
      fails++;
      $display("FAIL idle_after_reset: got rdy=%b hold=%b done=%b err=%b, required 0000",
               in_ready, cpu_hold, done, error);
    end
  endtask

  task automatic test_basic();
    for (int c = 0; c < 2; c++) begin
      basic_stream();
      if (c == 1) tx[7] = 8'h00;
      got.delete();
      stray = 0;
      pulse_start();
      checks++;
      if ({in_ready, cpu_hold} !== 2'b11) begin
        fails++;
        $display("FAIL basic_start_%0d: got rdy=%b hold=%b, required 1 1", c, in_ready, cpu_hold);
      end
      drive_range(0, 7, 0);
      build_expect();
      checks++;
      if (got.size() != 3 || got[0] !== 32'h0000_3111 || got[1] !== 32'h0002_3222 ||
          got[2] !== 32'h0004_0210) begin
        fails++;
        $display("FAIL basic_writes_%0d: got %0d writes first=%h, required 3 writes 00003111 00023222 00040210",
                 c, got.size(), (got.size() > 0) ? got[0] : 32'hx);
      end
      checks++;
      if ({done, error, cpu_hold, in_ready} !== {exp_done, exp_err, 2'b00}) begin
        fails++;
        $display("FAIL basic_status_%0d: got done=%b err=%b hold=%b rdy=%b, required done=%b err=%b hold=0 rdy=0",
                 c, done, error, cpu_hold, in_ready, exp_done, exp_err);
      end
    end
  endtask

  task automatic test_count_bounds();
    int ns[3] = '{0, 33, 32};
    for (int c = 0; c < 3; c++) begin
      make_stream(ns[c], 1'b1, 1'b1);
      got.delete();
      stray = 0;
      pulse_start();
      drive_range(0, tx.size() - 1, 0);
      build_expect();
      checks++;
      if (got.size() != exp_w.size()) begin
        fails++;
        $display("FAIL bounds_n%0d_count: got %0d writes, required %0d", ns[c], got.size(), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_w[i]) begin
          fails++;
          $display("FAIL bounds_n%0d_write%0d: got %h, required %h", ns[c], i, got[i], exp_w[i]);
        end
      end
      if (ns[c] == 32) begin
        checks++;
        if (got.size() == 0 || got[got.size() - 1][31:16] !== 16'd62) begin
          fails++;
          $display("FAIL bounds_last_addr: got %h, required 003e",
                   (got.size() > 0) ? got[got.size() - 1][31:16] : 16'hx);
        end
      end
      checks++;
      if ({done, error, cpu_hold, in_ready} !== {exp_done, exp_err, 2'b00}) begin
        fails++;
        $display("FAIL bounds_n%0d_status: got done=%b err=%b hold=%b rdy=%b, required done=%b err=%b hold=0 rdy=0",
                 ns[c], done, error, cpu_hold, in_ready, exp_done, exp_err);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 8; r++) begin
      make_stream((r == 0) ? 3 : int'($urandom_range(34, 0)), ($urandom_range(3, 0) != 0), 1'b0);
      if (r == 0) basic_stream();
      got.delete();
      stray = 0;
      pulse_start();
      drive_range(0, tx.size() - 1, 5);
      build_expect();
      checks++;
      if (got.size() != exp_w.size()) begin
        fails++;
        $display("FAIL gaps%0d_count: got %0d writes, required %0d", r, got.size(), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_w[i]) begin
          fails++;
          $display("FAIL gaps%0d_write%0d: got %h, required %h", r, i, got[i], exp_w[i]);
        end
      end
      checks++;
      if ({done, error, cpu_hold, in_ready} !== {exp_done, exp_err, 2'b00}) begin
        fails++;
        $display("FAIL gaps%0d_status: got done=%b err=%b hold=%b rdy=%b, required done=%b err=%b hold=0 rdy=0",
                 r, done, error, cpu_hold, in_ready, exp_done, exp_err);
      end
      checks++;
      if (stray != 0) begin
        fails++;
        $display("FAIL gaps%0d_stray_we: got %0d unexpected writes, required 0", r, stray);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    basic_stream();
    got.delete();
    stray = 0;
    pulse_start();
    drive_range(0, 3, 0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error} !== 37'd0) begin
      fails++;
      $display("FAIL midload_reset_outputs: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b, required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
    end
    #2 reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (got.size() != 1 || stray != 0) begin
      fails++;
      $display("FAIL midload_writes: got %0d writes (%0d stray), required 1 (0 stray)", got.size(), stray);
    end
    make_stream(5, 1'b1, 1'b0);
    got.delete();
    pulse_start();
    drive_range(0, tx.size() - 1, 2);
    build_expect();
    checks++;
    if (got != exp_w || {done, error, cpu_hold} !== 3'b100) begin
      fails++;
      $display("FAIL midload_reload: got %0d writes done=%b err=%b hold=%b, required %0d matching writes done=1 err=0 hold=0",
               got.size(), done, error, cpu_hold, exp_w.size());
    end
  endtask

  task automatic test_restart();
    make_stream(4, 1'b1, 1'b0);
    got.delete();
    stray = 0;
    pulse_start();
    drive_range(0, 0, 0);
    pulse_start();
    drive_range(1, tx.size() - 1, 0);
    build_expect();
    checks++;
    if (got != exp_w || {done, error} !== 2'b10) begin
      fails++;
      $display("FAIL restart_in_hi: got %0d writes done=%b err=%b, required %0d matching writes done=1 err=0",
               got.size(), done, error, exp_w.size());
    end
    pulse_start();
    checks++;
    if ({done, error, cpu_hold, in_ready} !== 4'b0011) begin
      fails++;
      $display("FAIL restart_from_done: got done=%b err=%b hold=%b rdy=%b, required 0 0 1 1",
               done, error, cpu_hold, in_ready);
    end
    make_stream(2, 1'b1, 1'b0);
    got.delete();
    drive_range(0, tx.size() - 1, 1);
    build_expect();
    checks++;
    if (got != exp_w || {done, error, cpu_hold} !== 3'b100) begin
      fails++;
      $display("FAIL restart_reload: got %0d writes first=%h done=%b, required %0d writes from addr 0 done=1",
               got.size(), (got.size() > 0) ? got[0] : 32'hx, done, exp_w.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_count_bounds();
    test_backpressure();
    test_reset_mid_load();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-serial program loader that writes 16-bit instruction words into the instruction memory's write port before the CPU runs. It accepts a framed byte stream (word count, big-endian instruction words, XOR checksum) over a valid/ready handshake. Words land at byte addresses 0, 2, 4, … to match the PC stepping used by fetch. The loader holds the CPU via `cpu_hold` for the whole load.

## Interface
Parameters:
- `DEPTH`, default 64: number of memory locations; the highest writable address is DEPTH-2.
- `ADDR_STEP`, default 2: address increment per word.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a load when the loader is in IDLE, DONE or ERROR.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte; a byte transfers when `in_valid & in_ready` at a rising edge.
- `mem_we`  out  1  single-cycle write strobe to the instruction memory.
- `mem_addr`  out  16  write address, registered.
- `mem_wdata`  out  16  write data, registered.
- `cpu_hold`  out  1  keeps the CPU stalled/reset while high.
- `done`  out  1  level; load completed and checksum matched.
- `error`  out  1  level; bad word count or checksum mismatch.

## Operation
- States: IDLE, COUNT, HI, LO, CHECK, DONE, ERROR.
- Reset (async, any state): state=IDLE; `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=0, `done`=0, `error`=0; internal word counter, address and checksum cleared.
- IDLE/DONE/ERROR + `start`:
  - go to COUNT;
  - clear `done`/`error`, the checksum and the address;
  - set `cpu_hold`=1.
- `start` in COUNT/HI/LO/CHECK is ignored.
- COUNT: accept byte N.
  - N=0 or N > DEPTH/ADDR_STEP (32 by default): go to ERROR.
  - Otherwise remaining=N and go to HI.
  - The count byte is not included in the checksum.
- HI: accept a byte, store it as word[15:8], checksum ^= byte, go to LO.
- LO: accept a byte and form word = {hi, byte}; checksum ^= byte.
  - Next cycle: `mem_we`=1, `mem_wdata`=word, `mem_addr`=current address.
  - Then address += ADDR_STEP and remaining -= 1.
  - Go to HI if remaining is still nonzero after the decrement, else go to CHECK.
- CHECK: accept a byte.
  - Byte == checksum: go to DONE, `done`=1.
  - Otherwise: go to ERROR, `error`=1.
- `cpu_hold` drops to 0 on entry to DONE or ERROR.
- Words written before an error stay written; they are not rolled back.
- `in_ready`=1 exactly in COUNT, HI, LO and CHECK; it is registered with the state.
- Address arithmetic is 16-bit. The count check guarantees the address never exceeds DEPTH-ADDR_STEP, so there is no wrap.
- Reset during a load aborts it immediately. Any partially assembled word is discarded and not written.

## Timing
- One byte per cycle maximum; there is no bubble between words.
- `mem_we` pulses exactly 1 cycle, in the cycle after the LO byte handshake. The next HI byte may be accepted in that same cycle.
- `mem_addr`/`mem_wdata` stay valid while `mem_we`=1 and hold their last value otherwise.
- `start` at edge t: `in_ready`=1 and `cpu_hold`=1 from t+1.
- The final checksum handshake at edge t: `done` or `error` rises at t+1, and `cpu_hold` and `in_ready` fall at t+1.
- Minimum load time for N words: 1+2N+1 byte cycles, plus 1 cycle after `start`.
- `in_valid` held low stalls the FSM indefinitely with no state change.

## Test plan
- Basic load: stream 03, 31 11, 32 22, 02 10 (checksum 0x22 XOR'd over the data bytes) with `in_valid` continuous. Required: three `mem_we` pulses at addr 0/2/4 with data 0x3111/0x3222/0x0210, then `done`=1, `cpu_hold`=0.
- Bad checksum: same stream ending in 0x00. Required: all three writes occur, then `error`=1, `done`=0, `cpu_hold`=0.
- Count bounds:
  - N=0: ERROR with no write.
  - N=33: ERROR with no write.
  - N=32 of 0xFFFF words: the last write is at addr 62, then `done`.
- Backpressure gaps: random `in_valid` gaps of 0-5 cycles. Required: identical writes and result, and no `mem_we` except after an LO handshake.
- Reset mid-load: assert `reset` after the HI byte of word 2. Required: outputs return to reset values asynchronously, no write of word 2, IDLE; a following `start` plus a full stream loads correctly from addr 0.
- Restart: `start` during HI is ignored; `start` in DONE clears `done`, re-asserts `cpu_hold`, and restarts at addr 0.
